// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the Wishbone address decoder.
//   - Default parameter values used by wb_addr_decoder_n.
//   - FSM state encoding (IDLE, BUSY, RESP) as plain localparams so the
//     encoding stays identical across tools that lack enum support.
package wb_pkg;

    localparam int unsigned DefAddrW     = 8;
    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefNumSlaves = 4;
    localparam int unsigned DefRegionW   = 4;
    localparam int unsigned DefTimeout   = 15;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: cycle counter that flags when a slave has been waited
// on for TIMEOUT cycles.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset
//   clear_i   in  restart the count at zero
//   enable_i  in  count this cycle
//   expire_o  out count has reached TIMEOUT-1 (last allowed wait cycle)
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT = wb_pkg::DefTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturate at the expiry value; the owner leaves its wait state then anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_addr_decoder_n.sv
// wb_addr_decoder_n: one Wishbone master fanned out to NUM_SLAVES slaves by
// the top REGION_W address bits. The request is latched when accepted, so the
// master may change adr/dat/we afterwards without disturbing the slave.
// Unmapped regions and slave timeouts complete with wb_err_o and ERR_DATA.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_adr_i/wb_dat_i/wb_we_i         master address, write data, write enable
//   wb_cyc_i/wb_stb_i                 master cycle, strobe
//   wb_dat_o/wb_ack_o/wb_err_o        master read data, success, error
//   s_wb_adr_o/s_wb_dat_o             per-slave address / write data (slice i)
//   s_wb_cyc_o/s_wb_stb_o/s_wb_we_o   per-slave cycle, strobe, write enable
//   s_wb_dat_i/s_wb_ack_i             per-slave read data, ack
module wb_addr_decoder_n
    import wb_pkg::*;
#(
    parameter int unsigned          ADDR_W     = DefAddrW,
    parameter int unsigned          DATA_W     = DefDataW,
    parameter int unsigned          NUM_SLAVES = DefNumSlaves,
    parameter int unsigned          REGION_W   = DefRegionW,
    parameter int unsigned          TIMEOUT    = DefTimeout,
    parameter logic [DATA_W-1:0]    ERR_DATA   = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              wb_adr_i,
    input  logic [DATA_W-1:0]              wb_dat_i,
    output logic [DATA_W-1:0]              wb_dat_o,
    input  logic                           wb_we_i,
    input  logic                           wb_cyc_i,
    input  logic                           wb_stb_i,
    output logic                           wb_ack_o,
    output logic                           wb_err_o,
    output logic [NUM_SLAVES*ADDR_W-1:0]   s_wb_adr_o,
    output logic [NUM_SLAVES*DATA_W-1:0]   s_wb_dat_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_wb_dat_i,
    output logic [NUM_SLAVES-1:0]          s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]          s_wb_we_o,
    input  logic [NUM_SLAVES-1:0]          s_wb_ack_i
);

    logic [1:0]          state_q, state_d;
    logic [REGION_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [REGION_W-1:0] region;
    logic                mapped;
    logic                busy;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_dat;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_expire;

    assign region = wb_adr_i[ADDR_W-1 -: REGION_W];
    assign mapped = (32'(region) < NUM_SLAVES);
    assign busy   = (state_q == StBusy);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    // Slave-side fan-out: only the latched slave sees anything, and only in BUSY.
    // Acks from other slaves (or outside BUSY) never reach sel_ack.
    always_comb begin
        s_wb_cyc_o = '0;
        s_wb_stb_o = '0;
        s_wb_we_o  = '0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        sel_ack    = 1'b0;
        sel_dat    = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (busy && (idx_q == REGION_W'(i))) begin
                s_wb_cyc_o[i]                  = 1'b1;
                s_wb_stb_o[i]                  = 1'b1;
                s_wb_we_o[i]                   = we_q;
                s_wb_adr_o[i*ADDR_W +: ADDR_W] = adr_q;
                s_wb_dat_o[i*DATA_W +: DATA_W] = dat_q;
                sel_ack                        = s_wb_ack_i[i];
                sel_dat                        = s_wb_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d = region;
                    adr_d = wb_adr_i;
                    dat_d = wb_dat_i;
                    we_d  = wb_we_i;
                    if (mapped) begin
                        state_d     = StBusy;
                        err_d       = 1'b0;
                        timer_clear = 1'b1;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            StBusy: begin
                // Master abandoning the cycle beats everything, then ack beats timeout.
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (sel_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    rdata_d = sel_dat;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expire) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign wb_ack_o = (state_q == StResp) && !err_q;
    assign wb_err_o = (state_q == StResp) && err_q;
    assign wb_dat_o = (state_q == StResp) ? rdata_q : '0;

endmodule

// File: tb/tb_wb_addr_decoder_n.sv
// tb_wb_addr_decoder_n: directed self-checking bench for wb_addr_decoder_n
// at default parameters (8-bit address, region = adr[7:4], 4 slaves).
module tb_wb_addr_decoder_n;

    logic        clk;
    logic        rst;
    logic [7:0]  wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] s_wb_adr_o;
    logic [31:0] s_wb_dat_o;
    logic [31:0] s_wb_dat_i;
    logic [3:0]  s_wb_cyc_o;
    logic [3:0]  s_wb_stb_o;
    logic [3:0]  s_wb_we_o;
    logic [3:0]  s_wb_ack_i;

    int checks;
    int errors;
    int stb_cnt;

    wb_addr_decoder_n dut (
        .clk        (clk),
        .rst        (rst),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .s_wb_adr_o (s_wb_adr_o),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_dat_i (s_wb_dat_i),
        .s_wb_cyc_o (s_wb_cyc_o),
        .s_wb_stb_o (s_wb_stb_o),
        .s_wb_we_o  (s_wb_we_o),
        .s_wb_ack_i (s_wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        wb_adr_i   = 8'h00;
        wb_dat_i   = 8'h00;
        wb_we_i    = 1'b0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        s_wb_dat_i = 32'h0;
        s_wb_ack_i = 4'b0;
        tick();
        tick();

        // Reset state
        check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        check("rst_err", {31'b0, wb_err_o}, 32'h0);
        check("rst_dat", {24'b0, wb_dat_o}, 32'h0);
        check("rst_scyc", {28'b0, s_wb_cyc_o}, 32'h0);
        check("rst_sstb", {28'b0, s_wb_stb_o}, 32'h0);
        check("rst_sadr", s_wb_adr_o, 32'h0);

        // Write 0x5A to 0x12; slave 1 acks two cycles after its strobe starts
        rst      = 1'b0;
        wb_adr_i = 8'h12;
        wb_dat_i = 8'h5A;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        check("wr_scyc", {28'b0, s_wb_cyc_o}, 32'h2);
        check("wr_sstb", {28'b0, s_wb_stb_o}, 32'h2);
        check("wr_swe", {28'b0, s_wb_we_o}, 32'h2);
        check("wr_sadr", s_wb_adr_o, 32'h0000_1200);
        check("wr_sdat", s_wb_dat_o, 32'h0000_5A00);
        check("wr_ack_early", {31'b0, wb_ack_o}, 32'h0);
        // Master scribbles on its bus; the latched request must not change
        wb_adr_i = 8'h99;
        wb_dat_i = 8'h00;
        wb_we_i  = 1'b0;
        tick();
        check("wr_hold_adr", s_wb_adr_o, 32'h0000_1200);
        check("wr_hold_dat", s_wb_dat_o, 32'h0000_5A00);
        check("wr_hold_we", {28'b0, s_wb_we_o}, 32'h2);
        tick();
        check("wr_sstb3", {28'b0, s_wb_stb_o}, 32'h2);
        s_wb_ack_i = 4'b0010;
        tick();
        check("wr_ack", {31'b0, wb_ack_o}, 32'h1);
        check("wr_err", {31'b0, wb_err_o}, 32'h0);
        check("wr_sstb_off", {28'b0, s_wb_stb_o}, 32'h0);
        s_wb_ack_i = 4'b0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        tick();
        check("wr_ack_once", {31'b0, wb_ack_o}, 32'h0);
        check("wr_dat_idle", {24'b0, wb_dat_o}, 32'h0);

        // Read 0x35; slave 3 returns 0xC3, slave 0 acks spuriously
        wb_adr_i = 8'h35;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        check("rd_sstb", {28'b0, s_wb_stb_o}, 32'h8);
        check("rd_swe", {28'b0, s_wb_we_o}, 32'h0);
        check("rd_sadr", s_wb_adr_o, 32'h3500_0000);
        s_wb_dat_i = 32'hC377_6655;
        s_wb_ack_i = 4'b1001;
        tick();
        check("rd_ack", {31'b0, wb_ack_o}, 32'h1);
        check("rd_err", {31'b0, wb_err_o}, 32'h0);
        check("rd_dat", {24'b0, wb_dat_o}, 32'hC3);
        s_wb_ack_i = 4'b0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        tick();
        check("rd_ack_once", {31'b0, wb_ack_o}, 32'h0);

        // Acks while idle are ignored
        s_wb_ack_i = 4'b1111;
        tick();
        check("idle_ack_ignored", {31'b0, wb_ack_o}, 32'h0);
        s_wb_ack_i = 4'b0;

        // Unmapped access to 0x70
        wb_adr_i = 8'h70;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        check("um_sstb", {28'b0, s_wb_stb_o}, 32'h0);
        check("um_err", {31'b0, wb_err_o}, 32'h1);
        check("um_ack", {31'b0, wb_ack_o}, 32'h0);
        check("um_dat", {24'b0, wb_dat_o}, 32'hFF);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick();
        check("um_err_once", {31'b0, wb_err_o}, 32'h0);
        check("um_dat_idle", {24'b0, wb_dat_o}, 32'h0);

        // Timeout: slave 0 never acks
        wb_adr_i = 8'h05;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        stb_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (wb_err_o) break;
            if (s_wb_stb_o[0]) stb_cnt++;
            tick();
        end
        check("to_err", {31'b0, wb_err_o}, 32'h1);
        check("to_stb_cycles", stb_cnt, 32'd15);
        check("to_dat", {24'b0, wb_dat_o}, 32'hFF);
        check("to_ack", {31'b0, wb_ack_o}, 32'h0);
        check("to_sstb_off", {28'b0, s_wb_stb_o}, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick();
        check("to_err_once", {31'b0, wb_err_o}, 32'h0);

        // Abort: master drops cyc three cycles into BUSY
        wb_adr_i = 8'h2A;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        tick();
        tick();
        check("ab_sstb_busy", {28'b0, s_wb_stb_o}, 32'h4);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick();
        check("ab_sstb_off", {28'b0, s_wb_stb_o}, 32'h0);
        check("ab_ack", {31'b0, wb_ack_o}, 32'h0);
        check("ab_err", {31'b0, wb_err_o}, 32'h0);
        tick();
        check("ab_quiet", {30'b0, wb_ack_o, wb_err_o}, 32'h0);
        // Follow-up write to slave 2 completes normally
        wb_adr_i = 8'h2B;
        wb_dat_i = 8'h3C;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        check("ab2_sstb", {28'b0, s_wb_stb_o}, 32'h4);
        check("ab2_sdat", s_wb_dat_o, 32'h003C_0000);
        check("ab2_sadr", s_wb_adr_o, 32'h002B_0000);
        s_wb_dat_i = 32'h0011_0000;
        s_wb_ack_i = 4'b0100;
        tick();
        check("ab2_ack", {31'b0, wb_ack_o}, 32'h1);
        check("ab2_dat", {24'b0, wb_dat_o}, 32'h11);
        s_wb_ack_i = 4'b0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        tick();

        // Reset mid-BUSY with a same-cycle slave ack
        wb_adr_i = 8'h12;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        tick();
        tick();
        rst        = 1'b1;
        s_wb_ack_i = 4'b0010;
        tick();
        check("rb_ack", {31'b0, wb_ack_o}, 32'h0);
        check("rb_err", {31'b0, wb_err_o}, 32'h0);
        check("rb_dat", {24'b0, wb_dat_o}, 32'h0);
        check("rb_sstb", {28'b0, s_wb_stb_o}, 32'h0);
        check("rb_sadr", s_wb_adr_o, 32'h0);
        rst        = 1'b0;
        s_wb_ack_i = 4'b0;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        tick();
        check("rb_quiet", {30'b0, wb_ack_o, wb_err_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
